spi_phase_rx: RTL and testbench
===============================

Name: spi_phase_rx

Overview:
- Receive-side deserializer for the phase-detector serial link (serial_clk / serial_out / serial_valid, driven by the spi_go master).
- Oversamples the link in the local clk domain and recovers DATA_LENGTH-bit frames, MSB first.
- Presents each good frame on a valid/ready output port and counts malformed frames and overflows.
- Sits in the capture FPGA or test harness ahead of a FIFO or logger.

Parameters:
- DATA_LENGTH, 16, bits per frame (must match the transmitter).
- SYNC_STAGES, 2, synchronizer flops per serial input (≥2).
- ERR_CNT_W, 8, width of the error and overflow counters (saturating).

Ports:
- clk  in  1  local oversampling clock; must be ≥4× serial_clk.
- rst_n  in  1  asynchronous active-low reset.
- serial_clk  in  1  link clock from transmitter (MCLK); asynchronous to clk.
- serial_data  in  1  link data (MISO of the transmitter).
- serial_ss_n  in  1  frame enable, active low.
- data_out  out  DATA_LENGTH  received word.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts the word when data_valid && data_ready.
- phase_out  out  8  data_out[7:0]; the phase field.
- frame_err_cnt  out  ERR_CNT_W  count of frames with a wrong bit count.
- overflow_cnt  out  ERR_CNT_W  count of good frames dropped because the holding register was full.
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset values (async assert, sync release internally): data_out = 0, data_valid = 0, frame_err_cnt = 0, overflow_cnt = 0, busy = 0, state = IDLE, shift register = 0, bit counter = 0. The synchronizer flops reset to 1 for ss_n and 0 for clk and data.
- Inputs: serial_clk, serial_data and serial_ss_n each pass through SYNC_STAGES flops.
- Edge detection: sclk_rise = sync_clk && !sync_clk_d; ss_fall and ss_rise are derived the same way.
- Sampling: data is sampled on sclk_rise (mode 0, MSB first) using the synchronized data bit aligned to the same stage.
- IDLE:
  - ss_fall → SHIFT; clear bit counter and shift register.
  - sclk_rise in IDLE is ignored.
- SHIFT:
  - Each sclk_rise: shift_reg <= {shift_reg[DATA_LENGTH-2:0], data_bit}.
  - Bit counter increments and saturates at DATA_LENGTH+1, so extra bits register as an error.
  - busy = 1.
  - ss_rise → CHECK. If ss_rise and sclk_rise occur in the same cycle, the bit is sampled first, then → CHECK.
- CHECK (one cycle):
  - If count == DATA_LENGTH: the frame is good.
  - Otherwise frame_err_cnt increments (saturating at all-ones), the frame is discarded, and the state returns to IDLE.
- Good frame, in the CHECK cycle:
  - If !data_valid, or data_valid && data_ready in the same cycle: data_out <= shift_reg and data_valid <= 1 in the next cycle.
  - Else: overflow_cnt increments (saturating), the old word is kept, and the new word is dropped.
  - Next state is IDLE.
- Output handshake:
  - data_valid falls the cycle after data_valid && data_ready unless a new word is loaded in the same cycle.
  - data_out is stable while data_valid && !data_ready.
- Latency: data_valid rises SYNC_STAGES+3 clk cycles after the raw serial_ss_n rising edge (sync + edge detect + CHECK + load).
- phase_out is combinational from data_out.
- ss_fall seen while in CHECK: the state goes to SHIFT directly after CHECK completes, provided ss_n is still low; back-to-back frames with ≥1 clk of ss_n high are not lost.
- Reset asserted mid-frame: all state is cleared immediately. After release, the block waits for a fresh ss_fall; a partial frame in progress is ignored.

Test Plan:
- Single frame 16'hA5C3, serial_clk = clk/8, then hold ready high → data_out = A5C3, phase_out = C3, data_valid high for 1 cycle, both counters = 0.
- Frame with 15 clocks, then a frame with 17 clocks → frame_err_cnt = 2, data_valid never asserts; a following good 16'h0001 is received correctly.
- ready held low, frames 16'h1111 then 16'h2222 → data_out stays 1111, overflow_cnt = 1. After ready pulses, data_valid = 0.
- Back-to-back frames 16'hFFFF, 16'h0000, 16'h8001 with 2-clk ss_n gaps, ready high → three words delivered in order, no errors.
- rst_n pulsed low after 7 bits of 16'hBEEF, frame continues → no output, no error counted. Next full frame 16'h1234 → received correctly.
- 300 malformed frames → frame_err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/spi_phase_rx_if.sv
// rtl/spi_phase_rx_if.sv - serial link and received-word handshake bundle for spi_phase_rx
interface spi_phase_rx_if #(
  parameter int DATA_LENGTH = 16
);
  logic                   serial_clk;
  logic                   serial_data;
  logic                   serial_ss_n;
  logic [DATA_LENGTH-1:0] data_out;
  logic                   data_valid;
  logic                   data_ready;
  logic [7:0]             phase_out;

  // Receiver side: consumes the link, produces words
  modport slave (
    input  serial_clk, serial_data, serial_ss_n, data_ready,
    output data_out, data_valid, phase_out
  );

  // Transmitter/consumer side: drives the link, accepts words
  modport master (
    output serial_clk, serial_data, serial_ss_n, data_ready,
    input  data_out, data_valid, phase_out
  );
endinterface

// File: rtl/spi_phase_rx.sv
// rtl/spi_phase_rx.sv - oversampling deserializer for the phase-detector serial link
module spi_phase_rx #(
  parameter int DATA_LENGTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_phase_rx_if.slave        link,
  output logic [ERR_CNT_W-1:0] frame_err_cnt,
  output logic [ERR_CNT_W-1:0] overflow_cnt,
  output logic                 busy
);

  localparam int CNT_W    = $clog2(DATA_LENGTH + 2);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(DATA_LENGTH);
  localparam logic [CNT_W-1:0]    CNT_SAT     = CNT_W'(DATA_LENGTH + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Reset: asserts asynchronously, releases on a clk edge
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Reset release synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Input synchronizers; ss_n idles high so its chain resets to ones
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sclk_s;
  logic                   sdata_s;
  logic                   ss_s;

  // Multi-flop synchronizers for the three asynchronous link inputs
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      ss_sync_q    <= '1;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], link.serial_clk};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], link.serial_data};
      ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], link.serial_ss_n};
    end
  end

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];

  // Registered edge pulses. The data bit is registered alongside the clock
  // edge so both come from the same synchronizer stage. A frame start is only
  // accepted once ss_n has been seen high after the chains have refilled from
  // the pins, so a frame already in flight at reset release is ignored.
  logic                sclk_d_q;
  logic                ss_d_q;
  logic                sclk_rise_q;
  logic                ss_fall_q;
  logic                ss_rise_q;
  logic                bit_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                armed_q;

  // Edge detection and post-reset arming
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sclk_d_q    <= 1'b0;
      ss_d_q      <= 1'b1;
      sclk_rise_q <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      bit_q       <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_d_q    <= sclk_s;
      ss_d_q      <= ss_s;
      sclk_rise_q <= sclk_s & ~sclk_d_q;
      ss_fall_q   <= armed_q & ~ss_s & ss_d_q;
      ss_rise_q   <= ss_s & ~ss_d_q;
      bit_q       <= sdata_s;
      if (settle_q != SETTLE_DONE) settle_q <= settle_q + 1'b1;
      else if (ss_s)               armed_q  <= 1'b1;
    end
  end

  state_t                 state_q;
  logic [DATA_LENGTH-1:0] shift_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_LENGTH-1:0] data_q;
  logic                   valid_q;
  logic [ERR_CNT_W-1:0]   err_q;
  logic [ERR_CNT_W-1:0]   ovf_q;
  logic                   busy_q;

  logic [DATA_LENGTH-1:0] shift_d;
  logic [CNT_W-1:0]       cnt_d;
  logic [ERR_CNT_W-1:0]   err_d;
  logic [ERR_CNT_W-1:0]   ovf_d;

  // Saturating increments and the shifted word
  always_comb begin
    shift_d = {shift_q[DATA_LENGTH-2:0], bit_q};
    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    err_d   = (err_q == '1) ? err_q : err_q + 1'b1;
    ovf_d   = (ovf_q == '1) ? ovf_q : ovf_q + 1'b1;
  end

  // Frame FSM with output holding register and error counters
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
      ovf_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      // A consumed word drops valid unless CHECK reloads it below
      if (valid_q && link.data_ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ss_fall_q) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end

        SHIFT: begin
          // A bit arriving with the ss_n rise is still taken
          if (sclk_rise_q) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
          end
          if (ss_rise_q) begin
            state_q <= CHECK;
            busy_q  <= 1'b0;
          end
        end

        CHECK: begin
          if (cnt_q == CNT_FULL) begin
            if (!valid_q || link.data_ready) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ovf_q <= ovf_d;
            end
          end else begin
            err_q <= err_d;
          end
          // A new frame starting during CHECK goes straight to SHIFT
          if (ss_fall_q) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            shift_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign link.data_out   = data_q;
  assign link.data_valid = valid_q;
  assign link.phase_out  = data_q[7:0];
  assign frame_err_cnt   = err_q;
  assign overflow_cnt    = ovf_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_spi_phase_rx.sv
// tb/tb_spi_phase_rx.sv - self-checking bench for spi_phase_rx
module tb_spi_phase_rx;

  localparam int DL = 16;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] frame_err_cnt;
  logic [7:0] overflow_cnt;
  logic       busy;

  spi_phase_rx_if #(.DATA_LENGTH(DL)) ifc ();

  spi_phase_rx #(.DATA_LENGTH(DL), .SYNC_STAGES(SS), .ERR_CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link          (ifc),
    .frame_err_cnt (frame_err_cnt),
    .overflow_cnt  (overflow_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Observed handshakes
  logic [DL-1:0] cap_q[$];
  int            vhigh = 0;

  always @(negedge clk) begin
    if (ifc.data_valid) vhigh++;
    if (ifc.data_valid && ifc.data_ready) cap_q.push_back(ifc.data_out);
  end

  // Reference model: frame-level view of what should be delivered
  logic [DL-1:0] exp_q[$];
  int            m_err = 0;
  int            m_ovf = 0;
  bit            m_hold = 0;
  logic [DL-1:0] m_word = '0;
  bit            m_rdy = 1;

  task automatic m_frame(input logic [DL-1:0] w, input int nbits);
    if (nbits != DL) begin
      if (m_err < 255) m_err++;
    end else if (m_rdy) begin
      exp_q.push_back(w);
    end else if (!m_hold) begin
      m_hold = 1;
      m_word = w;
    end else begin
      if (m_ovf < 255) m_ovf++;
    end
  endtask

  task automatic m_reset();
    m_err  = 0;
    m_ovf  = 0;
    m_hold = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame of nbits serial clocks at clk/8, mode 0, MSB first.
  // rst_bit > 0 pulses rst_n after that many bits while the frame continues.
  task automatic send(input logic [DL-1:0] w, input int nbits, input int rst_bit);
    ifc.serial_ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      ifc.serial_data = (i < DL) ? w[DL-1-i] : 1'($urandom_range(0, 1));
      tick(4);
      ifc.serial_clk = 1'b1;
      tick(4);
      ifc.serial_clk = 1'b0;
      if (i == 4 && nbits > 5) chk("busy_mid_frame", 32'(busy), 32'd1);
      if (rst_bit > 0 && i == rst_bit - 1) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        m_reset();
      end
    end
    tick(4);
    ifc.serial_ss_n = 1'b1;
  endtask

  task automatic compare_words(input string tag);
    int n;
    tick(30);
    chk({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, 32'(cap_q[i]), 32'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_counts(input string tag);
    chk({tag, "_frame_err_cnt"}, 32'(frame_err_cnt), 32'(m_err));
    chk({tag, "_overflow_cnt"}, 32'(overflow_cnt), 32'(m_ovf));
  endtask

  initial begin
    int lat;
    int vh0;
    logic [DL-1:0] w;
    int nb;

    ifc.serial_clk  = 1'b0;
    ifc.serial_data = 1'b0;
    ifc.serial_ss_n = 1'b1;
    ifc.data_ready  = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(6);

    // Reset state
    chk("rst_data_out", 32'(ifc.data_out), 32'h0);
    chk("rst_data_valid", 32'(ifc.data_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    compare_counts("rst");

    // Single frame, latency from ss_n rise, one-cycle valid
    vh0 = vhigh;
    send(16'hA5C3, DL, 0);
    m_frame(16'hA5C3, DL);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (ifc.data_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(SS + 3));
    tick(20);
    chk("single_valid_cycles", 32'(vhigh - vh0), 32'd1);
    chk("single_data_out", 32'(ifc.data_out), 32'hA5C3);
    chk("single_phase_out", 32'(ifc.phase_out), 32'hC3);
    chk("single_busy_idle", 32'(busy), 32'h0);
    compare_words("single");
    compare_counts("single");

    // Short, long and very long frames, then a good one
    vh0 = vhigh;
    send(16'h1357, 15, 0); m_frame(16'h1357, 15); tick(3);
    send(16'h2468, 17, 0); m_frame(16'h2468, 17); tick(3);
    tick(20);
    chk("badlen_no_valid", 32'(vhigh - vh0), 32'd0);
    compare_counts("badlen");
    send(16'h9999, 48, 0); m_frame(16'h9999, 48); tick(3);
    send(16'h0001, DL, 0); m_frame(16'h0001, DL); tick(3);
    compare_words("after_badlen");
    compare_counts("after_badlen");

    // Overflow with ready held low
    ifc.data_ready = 1'b0;
    m_rdy = 0;
    send(16'h1111, DL, 0); m_frame(16'h1111, DL); tick(20);
    send(16'h2222, DL, 0); m_frame(16'h2222, DL); tick(20);
    chk("ovf_data_out", 32'(ifc.data_out), 32'h1111);
    chk("ovf_data_valid", 32'(ifc.data_valid), 32'h1);
    compare_counts("ovf");
    ifc.data_ready = 1'b1;
    tick(1);
    ifc.data_ready = 1'b0;
    exp_q.push_back(m_word);
    m_hold = 0;
    tick(3);
    chk("ovf_valid_after_pulse", 32'(ifc.data_valid), 32'h0);
    ifc.data_ready = 1'b1;
    m_rdy = 1;
    compare_words("ovf");

    // Back-to-back frames with 2-clk gaps
    send(16'hFFFF, DL, 0); m_frame(16'hFFFF, DL); tick(2);
    send(16'h0000, DL, 0); m_frame(16'h0000, DL); tick(2);
    send(16'h8001, DL, 0); m_frame(16'h8001, DL);
    compare_words("b2b");
    compare_counts("b2b");

    // Random frames with random lengths and short gaps
    for (int f = 0; f < 25; f++) begin
      w  = 16'($urandom);
      nb = $urandom_range(0, 5);
      nb = (nb == 0) ? DL - 1 : (nb == 1) ? DL + 1 : DL;
      send(w, nb, 0);
      m_frame(w, nb);
      tick($urandom_range(1, 6));
    end
    compare_words("rand");
    compare_counts("rand");

    // Reset mid-frame: partial frame ignored, next frame good
    send(16'hBEEF, DL, 7);
    tick(20);
    chk("midrst_data_valid", 32'(ifc.data_valid), 32'h0);
    chk("midrst_data_out", 32'(ifc.data_out), 32'h0);
    compare_words("midrst");
    compare_counts("midrst");
    send(16'h1234, DL, 0); m_frame(16'h1234, DL);
    compare_words("after_midrst");
    compare_counts("after_midrst");

    // Error counter saturation
    for (int f = 0; f < 300; f++) begin
      nb = $urandom_range(0, 2);
      send(16'h0, nb, 0);
      m_frame(16'h0, nb);
      tick(2);
    end
    tick(20);
    chk("sat_frame_err_cnt", 32'(frame_err_cnt), 32'hFF);
    compare_counts("sat");
    compare_words("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
